// File: rtl/fp16_raddsub_pipe.sv
// fp16_raddsub_pipe: pipelined IEEE 754 binary16 adder/subtractor, round to
// nearest even, valid/ready on both ends, global stall on output backpressure.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready = !rst && !stall
//   in_a, in_b          operands {sign, exp[4:0], frac[9:0]}
//   in_sub              1: a - b, 0: a + b
//   out_valid/out_ready result handshake
//   out_r               FP16 result, held while out_valid && !out_ready
//
// Build option: define FP16_RADDSUB_SUBNORMAL_EN for gradual underflow;
// otherwise subnormal inputs and results flush to zero.
//
// Register levels: s0 unpack, s1 align, s2 add/sub, s3 normalize, s4 round,
// then the pack/output register, so an op accepted on edge N is visible on
// out_r after edge N+5.
module fp16_raddsub_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r
);
  localparam logic [15:0] QNAN = 16'h7E00;

  logic stall, adv;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !rst && !stall;
  assign adv      = !stall;

  // stage registers
  logic        s0_v, s1_v, s2_v, s3_v, s4_v;
  logic        s0_sp, s1_sp, s2_sp, s3_sp, s4_sp;
  logic [15:0] s0_spv, s1_spv, s2_spv, s3_spv, s4_spv;
  logic        s0_zs, s1_zs, s2_zs, s3_zs, s4_zs;
  logic        s0_sign, s1_sign, s2_sign, s3_sign, s4_sign;
  logic        s0_sub, s1_sub;
  logic [4:0]  s0_eb, s0_es, s1_e, s2_e;
  logic [10:0] s0_mb, s0_ms;
  logic [20:0] s1_mb, s1_ms, s3_m;
  logic [21:0] s2_sum;
  logic        s3_zero, s4_zero;
  logic [6:0]  s3_e, s4_e;
  logic [9:0]  s4_f;

  function automatic logic [4:0] lzc21(input logic [20:0] v);
    lzc21 = 5'd21;
    for (int i = 0; i <= 20; i++)
      if (v[i]) lzc21 = 5'(20 - i);
  endfunction

  // S0: unpack, classify specials, order operands by magnitude
  logic [4:0]  ea, eb, xa, xb;
  logic [10:0] ma, mb;
  logic        sa, sb, nan_a, nan_b, inf_a, inf_b, swap;
  logic        n0_sp;
  logic [15:0] n0_spv;
  always_comb begin
    ea = in_a[14:10];
    eb = in_b[14:10];
    sa = in_a[15];
    sb = in_b[15] ^ in_sub;
`ifdef FP16_RADDSUB_SUBNORMAL_EN
    xa = (ea == 5'd0) ? 5'd1 : ea;
    xb = (eb == 5'd0) ? 5'd1 : eb;
    ma = {ea != 5'd0, in_a[9:0]};
    mb = {eb != 5'd0, in_b[9:0]};
`else
    xa = ea;
    xb = eb;
    ma = (ea == 5'd0) ? 11'd0 : {1'b1, in_a[9:0]};
    mb = (eb == 5'd0) ? 11'd0 : {1'b1, in_b[9:0]};
`endif
    nan_a  = (ea == 5'h1F) && (in_a[9:0] != 10'd0);
    nan_b  = (eb == 5'h1F) && (in_b[9:0] != 10'd0);
    inf_a  = (ea == 5'h1F) && (in_a[9:0] == 10'd0);
    inf_b  = (eb == 5'h1F) && (in_b[9:0] == 10'd0);
    swap   = {xb, mb} > {xa, ma};
    n0_sp  = nan_a || nan_b || inf_a || inf_b;
    n0_spv = {sb, 5'h1F, 10'd0};
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) n0_spv = QNAN;
    else if (inf_a)                                       n0_spv = {sa, 5'h1F, 10'd0};
  end

  // S1: align small mantissa; bits shifted past the LSB fold into sticky
  logic [4:0]  n1_d;
  logic [41:0] n1_ext;
  logic [20:0] n1_ms;
  always_comb begin
    n1_d   = s0_eb - s0_es;
    n1_ext = {s0_ms, 10'd0, 21'd0} >> n1_d;
    n1_ms  = n1_ext[41:21] | {20'd0, |n1_ext[20:0]};
  end

  // S2: magnitude add/sub; big >= small so the difference is never negative
  logic [21:0] n2_sum;
  always_comb begin
    n2_sum = s1_sub ? ({1'b0, s1_mb} - {1'b0, s1_ms})
                    : ({1'b0, s1_mb} + {1'b0, s1_ms});
  end

  // S3: normalize so the hidden bit lands on bit 20
  logic [6:0]  e_in, n3_sh, n3_e;
  logic [20:0] n3_m;
  logic        n3_zero;
  always_comb begin
    e_in    = {2'b00, s2_e};
    n3_sh   = 7'(lzc21(s2_sum[20:0]));
    n3_m    = s2_sum[20:0];
    n3_e    = e_in;
    n3_zero = 1'b0;
    if (s2_sum[21]) begin
      n3_m = s2_sum[21:1] | {20'd0, s2_sum[0]};
      n3_e = e_in + 7'd1;
    end else begin
`ifdef FP16_RADDSUB_SUBNORMAL_EN
      // stop at exponent 1; a clear hidden bit then encodes a subnormal
      if (n3_sh > e_in - 7'd1) n3_sh = e_in - 7'd1;
      n3_zero = (s2_sum[20:0] == 21'd0);
`else
      n3_zero = (s2_sum[20:0] == 21'd0) || (e_in <= n3_sh);
`endif
      n3_m = s2_sum[20:0] << n3_sh;
      n3_e = e_in - n3_sh;
    end
  end

  // S4: round to nearest even on guard bit 9, sticky bits 8:0
  logic        n4_rnd;
  logic [11:0] n4_rm;
  logic [6:0]  n4_e;
  logic [9:0]  n4_f;
  always_comb begin
    n4_rnd = s3_m[9] & ((|s3_m[8:0]) | s3_m[10]);
    n4_rm  = {1'b0, s3_m[20:10]} + 12'(n4_rnd);
    n4_e   = n4_rm[10] ? s3_e : 7'd0;
    n4_f   = n4_rm[9:0];
    if (n4_rm[11]) begin
      n4_e = s3_e + 7'd1;
      n4_f = 10'd0;
    end
  end

  // pack: specials, zero sign, overflow to Inf
  logic [15:0] pack;
  always_comb begin
    pack = {s4_sign, s4_e[4:0], s4_f};
    if (s4_sp)              pack = s4_spv;
    else if (s4_zero)       pack = {s4_zs, 15'd0};
    else if (s4_e >= 7'd31) pack = {s4_sign, 5'h1F, 10'd0};
  end

  // valid chain and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v      <= 1'b0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s3_v      <= 1'b0;
      s4_v      <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= 16'h0000;
    end else if (adv) begin
      s0_v      <= in_valid && in_ready;
      s1_v      <= s0_v;
      s2_v      <= s1_v;
      s3_v      <= s2_v;
      s4_v      <= s3_v;
      out_valid <= s4_v;
      if (s4_v) out_r <= pack;
    end
  end

  // datapath registers, all held during a stall
  always_ff @(posedge clk) begin
    if (adv) begin
      s0_sp   <= n0_sp;    s0_spv  <= n0_spv;  s0_zs   <= sa & sb;
      s0_sign <= swap ? sb : sa;
      s0_sub  <= sa ^ sb;
      s0_eb   <= swap ? xb : xa;
      s0_es   <= swap ? xa : xb;
      s0_mb   <= swap ? mb : ma;
      s0_ms   <= swap ? ma : mb;

      s1_sp   <= s0_sp;    s1_spv  <= s0_spv;  s1_zs   <= s0_zs;
      s1_sign <= s0_sign;  s1_sub  <= s0_sub;  s1_e    <= s0_eb;
      s1_mb   <= {s0_mb, 10'd0};
      s1_ms   <= n1_ms;

      s2_sp   <= s1_sp;    s2_spv  <= s1_spv;  s2_zs   <= s1_zs;
      s2_sign <= s1_sign;  s2_e    <= s1_e;    s2_sum  <= n2_sum;

      s3_sp   <= s2_sp;    s3_spv  <= s2_spv;  s3_zs   <= s2_zs;
      s3_sign <= s2_sign;  s3_zero <= n3_zero; s3_e    <= n3_e;
      s3_m    <= n3_m;

      s4_sp   <= s3_sp;    s4_spv  <= s3_spv;  s4_zs   <= s3_zs;
      s4_sign <= s3_sign;  s4_zero <= s3_zero; s4_e    <= n4_e;
      s4_f    <= n4_f;
    end
  end

endmodule

// File: tb/tb_fp16_raddsub_pipe.sv
// Directed bench for fp16_raddsub_pipe: latency, arithmetic vectors,
// specials, backpressure and mid-flight reset, with hand-computed results.
module tb_fp16_raddsub_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_r;

  fp16_raddsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r)
  );

  always #5 clk = ~clk;

`ifdef FP16_RADDSUB_SUBNORMAL_EN
  localparam logic [15:0] SUB_EXP = 16'h0001;
`else
  localparam logic [15:0] SUB_EXP = 16'h0000;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [15:0] expq[$];
  logic        acc;
  int          idx;
  logic [15:0] bp_a[7];
  logic [15:0] bp_b[7];
  logic        bp_s[7];
  logic [15:0] bp_e[7];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, sample at negedge, score any result, advance past the edge.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic ordy, input logic [15:0] e,
                      input int exp_ov, input int exp_ir, output logic accepted);
    in_valid = v; in_a = a; in_b = b; in_sub = s; out_ready = ordy;
    @(negedge clk);
    accepted = v && in_ready;
    if (exp_ov >= 0) chk("out_valid", 16'(out_valid), 16'(exp_ov[0]));
    if (exp_ir >= 0) chk("in_ready", 16'(in_ready), 16'(exp_ir[0]));
    if (out_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL extra_result: observed=%h expected=none", out_r);
      end else begin
        chk("out_r", out_r, expq[0]);
        if (out_ready) void'(expq.pop_front());
      end
    end
    if (accepted) expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic s,
                    input logic [15:0] e);
    logic a_ok;
    step(1'b1, a, b, s, 1'b1, e, -1, 1, a_ok);
  endtask

  task automatic drain(input int n);
    logic d;
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, -1, -1, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_sub = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_r", out_r, 16'h0000);
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic stream: results visible 6 samples after the first issue step
    step(1'b1, 16'h3C00, 16'h3C00, 1'b0, 1'b1, 16'h4000, 0, 1, acc);
    step(1'b1, 16'h3C00, 16'h4000, 1'b0, 1'b1, 16'h4200, 0, 1, acc);
    step(1'b1, 16'h4000, 16'h3C00, 1'b1, 1'b1, 16'h3C00, 0, 1, acc);
    step(1'b1, 16'h3C00, 16'h4000, 1'b1, 1'b1, 16'hBC00, 0, 1, acc);
    for (int k = 4; k <= 10; k++)
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, (k >= 6 && k <= 9) ? 1 : 0, 1, acc);
    chk("basic_all_out", 16'(expq.size()), 16'd0);

    // rounding, overflow, specials, zero signs, underflow
    op(16'h3C00, 16'h1000, 1'b0, 16'h3C00);
    op(16'h3C01, 16'h1000, 1'b0, 16'h3C02);
    op(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00);
    op(16'h7C00, 16'h7C00, 1'b1, 16'h7E00);
    op(16'h7C00, 16'h3C00, 1'b0, 16'h7C00);
    op(16'h3C00, 16'h7C00, 1'b1, 16'hFC00);
    op(16'h7E01, 16'h0000, 1'b0, 16'h7E00);
    op(16'h3C00, 16'h3C00, 1'b1, 16'h0000);
    op(16'h8000, 16'h8000, 1'b0, 16'h8000);
    op(16'h8000, 16'h0000, 1'b1, 16'h8000);
    op(16'h0600, 16'h05FF, 1'b1, SUB_EXP);
    drain(10);
    chk("vec_all_out", 16'(expq.size()), 16'd0);

    // backpressure: out_ready low for samples 6..11 while seven ops issue
    bp_a = '{16'h3C00, 16'h3C00, 16'h4000, 16'h3C00, 16'h4000, 16'h3C01, 16'h7BFF};
    bp_b = '{16'h3C00, 16'h4000, 16'h3C00, 16'h4000, 16'h4000, 16'h1000, 16'h7BFF};
    bp_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bp_e = '{16'h4000, 16'h4200, 16'h3C00, 16'hBC00, 16'h4400, 16'h3C02, 16'h7C00};
    idx = 0;
    for (int k = 0; k < 20; k++) begin
      step(idx < 7, bp_a[idx % 7], bp_b[idx % 7], bp_s[idx % 7], (k < 6 || k > 11),
           bp_e[idx % 7], (k >= 6 && k <= 18) ? 1 : 0, (k < 6 || k > 11) ? 1 : 0, acc);
      if (acc) idx++;
    end
    chk("bp_issued", 16'(idx), 16'd7);
    chk("bp_all_out", 16'(expq.size()), 16'd0);

    // reset with four ops in flight
    op(16'h3C00, 16'h3C00, 1'b0, 16'h4000);
    op(16'h3C00, 16'h4000, 1'b0, 16'h4200);
    op(16'h4000, 16'h4000, 1'b0, 16'h4400);
    op(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00);
    rst = 1'b1;
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, -1, 0, acc);
    rst = 1'b0;
    expq.delete();
    @(negedge clk);
    chk("midrst_out_valid", 16'(out_valid), 16'd0);
    chk("midrst_out_r", out_r, 16'h0000);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++)
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, 0, 1, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
